// File: rtl/ann_pkg.sv
// Shared definitions for the ANN result collector: FSM state encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ann_pkg;

    localparam int N_CLASS_DEF = 10;
    localparam int IDX_W_DEF   = 4;

    // Class index reported when the captured vector has no set bit (all ones).
    localparam logic [IDX_W_DEF-1:0] NO_CLASS = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2,
        ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/ann_result_collector_if.sv
// Producer-to-collector bundle: result vector, four-phase handshake and decoded class outputs.
// Latency: n/a (wires only).
// Backpressure: producer holds out_ready until received rises, then drops it before the next result.
// Ports: out/out_ready driven by the producer (master); received, class_idx, hot_count,
//        class_valid driven by the collector (slave).
interface ann_result_collector_if
    import ann_pkg::*;
#(
    parameter int N_CLASS = N_CLASS_DEF,
    parameter int IDX_W   = IDX_W_DEF
);

    logic [0:N_CLASS-1] out;
    logic               out_ready;
    logic               received;
    logic [IDX_W-1:0]   class_idx;
    logic [IDX_W-1:0]   hot_count;
    logic               class_valid;

    modport master (
        output out, out_ready,
        input  received, class_idx, hot_count, class_valid
    );

    modport slave (
        input  out, out_ready,
        output received, class_idx, hot_count, class_valid
    );

endinterface

// File: rtl/ann_hist_bank.sv
// Per-class saturating result histogram (N_CLASS class bins plus one bin for "no class").
// Latency: increment lands on the edge after inc; read port is combinational.
// Backpressure: none; counters stick at all-ones instead of wrapping.
// Ports: clk, rst (sync, active-high), inc/inc_idx (bump the bin of inc_idx),
//        rd_sel/rd_count (read; out-of-range select reads 0).
// Only built when RESULT_HISTOGRAM_EN is defined.
`ifdef RESULT_HISTOGRAM_EN
module ann_hist_bank #(
    parameter int N_CLASS = 10,
    parameter int IDX_W   = 4,
    parameter int HIST_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [IDX_W-1:0]  inc_idx,
    input  logic [IDX_W-1:0]  rd_sel,
    output logic [HIST_W-1:0] rd_count
);

    localparam logic [IDX_W-1:0] NO_CLS  = '1;
    localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(N_CLASS);

    logic [HIST_W-1:0] bins [0:N_CLASS];

    // The "no class" code is folded onto the extra bin at index N_CLASS.
    logic [IDX_W-1:0] inc_slot;
    logic             inc_hit;

    always_comb begin
        inc_slot = inc_idx;
        inc_hit  = 1'b0;
        if (inc_idx < LAST_IX) begin
            inc_hit = 1'b1;
        end else if (inc_idx == NO_CLS) begin
            inc_slot = LAST_IX;
            inc_hit  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= N_CLASS; i++) begin
                bins[i] <= '0;
            end
        end else if (inc && inc_hit && (bins[inc_slot] != {HIST_W{1'b1}})) begin
            bins[inc_slot] <= bins[inc_slot] + 1'b1;
        end
    end

    always_comb begin
        rd_count = '0;
        if (rd_sel < LAST_IX) begin
            rd_count = bins[rd_sel];
        end else if (rd_sel == NO_CLS) begin
            rd_count = bins[N_CLASS];
        end
    end

endmodule
`endif

// File: rtl/ann_result_collector.sv
// Captures an output-layer result vector, scans it one bit per cycle for the winning class
// and hot count, then acknowledges the producer with a four-phase handshake.
// Latency: out_ready sampled at edge N -> class_valid/received after edge N+N_CLASS+1.
// Backpressure: a new vector is taken only from IDLE; received stays high until out_ready drops.
// Ports: clk, rst (sync, active-high); bus (slave side of ann_result_collector_if);
//        busy (not IDLE), total (8-bit wrapping result count), hist_sel/hist_count (histogram read).
// Optional: RESULT_HISTOGRAM_EN builds the per-class histogram; otherwise hist_count reads 0.
module ann_result_collector
    import ann_pkg::*;
#(
    parameter int N_CLASS = N_CLASS_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int HIST_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ann_result_collector_if.slave  bus,
    output logic                   busy,
    output logic [7:0]             total,
    input  logic [IDX_W-1:0]       hist_sel,
    output logic [HIST_W-1:0]      hist_count
);

    // All-ones code for "no bit set"; equals ann_pkg::NO_CLASS at the default width.
    localparam logic [IDX_W-1:0] NO_CLS   = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    state_t             state;
    logic [0:N_CLASS-1] cap;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   first_idx;
    logic               found;

    logic               received_q;
    logic               class_valid_q;
    logic [IDX_W-1:0]   class_idx_q;
    logic [IDX_W-1:0]   hot_count_q;
    logic [7:0]         total_q;

    logic [IDX_W-1:0]   result_idx;

    assign result_idx = found ? first_idx : NO_CLS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cap           <= '0;
            idx           <= '0;
            cnt           <= '0;
            first_idx     <= '0;
            found         <= 1'b0;
            received_q    <= 1'b0;
            class_valid_q <= 1'b0;
            class_idx_q   <= NO_CLS;
            hot_count_q   <= '0;
            total_q       <= '0;
        end else begin
            class_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.out_ready) begin
                        cap   <= bus.out;
                        idx   <= '0;
                        cnt   <= '0;
                        found <= 1'b0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (cap[idx]) begin
                        cnt <= cnt + 1'b1;
                        // Scan runs upward, so the first hit is the lowest index.
                        if (!found) begin
                            found     <= 1'b1;
                            first_idx <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    class_idx_q   <= result_idx;
                    hot_count_q   <= cnt;
                    class_valid_q <= 1'b1;
                    received_q    <= 1'b1;
                    total_q       <= total_q + 8'd1;
                    state         <= ACK;
                end
                ACK: begin
                    if (!bus.out_ready) begin
                        received_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.received    = received_q;
    assign bus.class_valid = class_valid_q;
    assign bus.class_idx   = class_idx_q;
    assign bus.hot_count   = hot_count_q;
    assign busy            = (state != IDLE);
    assign total           = total_q;

`ifdef RESULT_HISTOGRAM_EN
    ann_hist_bank #(
        .N_CLASS (N_CLASS),
        .IDX_W   (IDX_W),
        .HIST_W  (HIST_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .inc      (state == DONE),
        .inc_idx  (result_idx),
        .rd_sel   (hist_sel),
        .rd_count (hist_count)
    );
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_ann_result_collector.sv
// Randomized scoreboard bench for ann_result_collector: the driver pushes the expected
// class/count/total/arrival cycle per result; a monitor pops and compares on class_valid.
module tb_ann_result_collector;

    localparam int NC = 10;
    localparam int IW = 4;
    localparam int HW = 16;

    typedef struct {
        int cls;
        int cnt;
        int tot;
        int due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           busy;
    logic [7:0]     total;
    logic [IW-1:0]  hist_sel = '0;
    logic [HW-1:0]  hist_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   model_total = 0;
    int   hist_model [0:NC];
    exp_t sb [$];

    ann_result_collector_if #(.N_CLASS(NC), .IDX_W(IW)) bus ();

    ann_result_collector #(.N_CLASS(NC), .IDX_W(IW), .HIST_W(HW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .total      (total),
        .hist_sel   (hist_sel),
        .hist_count (hist_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: lowest set class (15 if none) and population count.
    function automatic exp_t model(input logic [0:NC-1] v, input int due);
        exp_t e;
        e.cls = 15;
        e.cnt = 0;
        for (int i = NC - 1; i >= 0; i--) begin
            if (v[i]) begin
                e.cls = i;
                e.cnt++;
            end
        end
        model_total = (model_total + 1) % 256;
        e.tot = model_total;
        e.due = due;
        begin
            int b;
            b = (e.cls == 15) ? NC : e.cls;
            if (hist_model[b] < 65535) hist_model[b]++;
        end
        return e;
    endfunction

    task automatic clear_model();
        model_total = 0;
        for (int i = 0; i <= NC; i++) hist_model[i] = 0;
    endtask

    task automatic check_reset_state();
        chk("rst_received", int'(bus.received), 0);
        chk("rst_class_valid", int'(bus.class_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_class_idx", int'(bus.class_idx), 15);
        chk("rst_hot_count", int'(bus.hot_count), 0);
    endtask

    // Called at a negedge with out_ready high: wait for received, hold, then release.
    task automatic finish_handshake(input int hold);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            bus.out = NC'($urandom);    // post-capture changes must be ignored
            got = bus.received;
        end
        if (!got) chk("received_timeout", 0, 1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            bus.out = NC'($urandom);    // no capture may happen while in ACK
            chk("ack_hold_received", int'(bus.received), 1);
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("ack_release_received", int'(bus.received), 0);
        chk("ack_release_busy", int'(busy), 0);
    endtask

    task automatic send(input logic [0:NC-1] v, input int hold);
        bus.out       = v;
        bus.out_ready = 1'b1;
        sb.push_back(model(v, cyc + NC + 2));
        finish_handshake(hold);
    endtask

    // Monitor: every class_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.class_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_class_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("class_idx", int'(bus.class_idx), e.cls);
                chk("hot_count", int'(bus.hot_count), e.cnt);
                chk("total", int'(total), e.tot);
                chk("latency_cycle", cyc, e.due);
                chk("received_with_valid", int'(bus.received), 1);
            end
        end
    end

    task automatic check_hist();
        for (int s = 0; s < 16; s++) begin
            int exp_h;
            hist_sel = IW'(s);
            #1;
`ifdef RESULT_HISTOGRAM_EN
            exp_h = (s < NC) ? hist_model[s] : ((s == 15) ? hist_model[NC] : 0);
`else
            exp_h = 0;
`endif
            chk("hist_count", int'(hist_count), exp_h);
        end
    endtask

    initial begin
        logic [0:NC-1] v;
        bus.out       = '0;
        bus.out_ready = 1'b0;
        clear_model();

        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        @(negedge clk);

        // Classes 2 and 5 set: winner 2, count 2.
        v = 10'b0010010000;
        send(v, 3);
        // Empty vector: NO_CLASS, still acknowledged and counted.
        send('0, 0);
        // Long ACK hold with changing out, then a one-cycle drop and class 9 only.
        v = 10'b1000000000;
        send(v, 6);
        v = 10'b0000000001;
        send(v, 0);

        // Reset during SCAN with out_ready still high: result abandoned, recaptured afterwards.
        v = 10'b0001100000;
        bus.out       = v;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        chk("sb_empty_before_reset", sb.size(), 0);
        clear_model();
        rst     = 1'b0;
        bus.out = v;
        sb.push_back(model(v, cyc + NC + 2));
        finish_handshake(1);

        // Random traffic, long enough to wrap total past 255.
        for (int n = 0; n < 270; n++) begin
            v = NC'($urandom);
            if ($urandom_range(0, 7) == 0) v = '0;
            else if ($urandom_range(0, 3) == 0) v = NC'(1) << $urandom_range(0, NC - 1);
            send(v, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("final_total", int'(total), model_total);
        check_hist();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
